// File: rtl/y_pkg.sv
// Shared definitions for the operand-fetch slice: datapath sizes, ALU op
// codes and the output-stage state encoding.
package y_pkg;

   // Datapath and register-file geometry.
   localparam int Y_WIDTH   = 32;
   localparam int Y_NREGS   = 32;
   localparam int Y_RADDR_W = 5;
   localparam int Y_OP_W    = 3;

   // ALU op codes understood downstream. The fetch stage forwards any
   // 3-bit code unchanged, so these are reference values, not a checked set.
   localparam logic [Y_OP_W-1:0] ALU_AND = 3'b000;
   localparam logic [Y_OP_W-1:0] ALU_OR  = 3'b001;
   localparam logic [Y_OP_W-1:0] ALU_ADD = 3'b010;
   localparam logic [Y_OP_W-1:0] ALU_SUB = 3'b110;
   localparam logic [Y_OP_W-1:0] ALU_SLT = 3'b111;

   // Output register occupancy: EMPTY means out_valid=0, FULL means out_valid=1.
   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } stage_state_e;

endpackage : y_pkg

// File: rtl/y_operand_fetch_if.sv
// Bundle of the fetch request, ALU-side output handshake and register-file
// write-back port. "slave" is the fetch stage's view, "master" is the view
// of whatever drives requests, consumes operands and commits results.
interface y_operand_fetch_if
   import y_pkg::*;
#(
   parameter int WIDTH = Y_WIDTH,
   parameter int NREGS = Y_NREGS
);

   localparam int AW = $clog2(NREGS);

   // Fetch request side.
   logic             in_valid;
   logic             in_ready;
   logic [AW-1:0]    rs_addr;
   logic [AW-1:0]    rt_addr;
   logic [WIDTH-1:0] imm;
   logic             use_imm;
   logic [Y_OP_W-1:0] op_in;

   // Operand output side toward the ALU.
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [Y_OP_W-1:0] op;

   // Write-back from the downstream stage.
   logic             wb_we;
   logic [AW-1:0]    wb_addr;
   logic [WIDTH-1:0] wb_data;

   modport slave (
      input  in_valid, rs_addr, rt_addr, imm, use_imm, op_in,
      input  out_ready,
      input  wb_we, wb_addr, wb_data,
      output in_ready,
      output out_valid, a, b, op
   );

   modport master (
      output in_valid, rs_addr, rt_addr, imm, use_imm, op_in,
      output out_ready,
      output wb_we, wb_addr, wb_data,
      input  in_ready,
      input  out_valid, a, b, op
   );

endinterface : y_operand_fetch_if

// File: rtl/y_rf_core.sv
// General-purpose register file storage: two asynchronous read ports, one
// synchronous write port, r0 hardwired to zero. No bypassing here; a read
// in the same cycle as a write to the same register sees the old value.
module y_rf_core
   import y_pkg::*;
#(
   parameter int WIDTH = Y_WIDTH,
   parameter int NREGS = Y_NREGS,
   localparam int AW   = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]    raddr_a_i,
   output logic [WIDTH-1:0] rdata_a_o,
   input  logic [AW-1:0]    raddr_b_i,
   output logic [WIDTH-1:0] rdata_b_o
);

   logic [WIDTH-1:0] regs_q [NREGS];

   // Register write; reset clears every register and wins over a write-back.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: this array is reset on purpose because every architectural
         // register must read 0 after reset; plain RAMs are normally left unreset.
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
      end else if (we_i && (waddr_i != '0)) begin
         // NOTE: non-blocking so every flop samples pre-edge values and
         // readers in other processes never see a half-updated file.
         regs_q[waddr_i] <= wdata_i;
      end
   end

   // r0 is forced to zero at the read mux; writes to it are already blocked.
   assign rdata_a_o = (raddr_a_i == '0) ? '0 : regs_q[raddr_a_i];
   assign rdata_b_o = (raddr_b_i == '0) ? '0 : regs_q[raddr_b_i];

endmodule : y_rf_core

// File: rtl/y_operand_fetch.sv
// Operand-fetch stage ahead of the 32-bit ALU. Reads rs/rt from the register
// file, optionally substitutes the immediate for b, and holds a/b/op in a
// valid/ready output register. Write-back commits into the register file.
// Optional feature: define Y_OPFETCH_BYPASS_EN to forward a same-edge
// write-back into a/b at accept time; without it a same-edge read returns
// the pre-write value and a one-cycle bubble is required.
module y_operand_fetch
   import y_pkg::*;
#(
   parameter int WIDTH = Y_WIDTH,
   parameter int NREGS = Y_NREGS
) (
   input  logic              clk,
   input  logic              rst,
   y_operand_fetch_if.slave  bus
);

   stage_state_e      state_q, state_d;
   logic [WIDTH-1:0]  a_q, a_d;
   logic [WIDTH-1:0]  b_q, b_d;
   logic [Y_OP_W-1:0] op_q, op_d;

   logic              in_ready;
   logic              accept;
   logic [WIDTH-1:0]  rf_a;
   logic [WIDTH-1:0]  rf_b;
   logic [WIDTH-1:0]  a_src;
   logic [WIDTH-1:0]  b_reg_src;
   logic [WIDTH-1:0]  b_src;

   y_rf_core #(
      .WIDTH (WIDTH),
      .NREGS (NREGS)
   ) u_rf (
      .clk       (clk),
      .rst       (rst),
      .we_i      (bus.wb_we),
      .waddr_i   (bus.wb_addr),
      .wdata_i   (bus.wb_data),
      .raddr_a_i (bus.rs_addr),
      .rdata_a_o (rf_a),
      .raddr_b_i (bus.rt_addr),
      .rdata_b_o (rf_b)
   );

   // The output register can take a new set when it is empty or being drained.
   assign in_ready = (state_q == ST_EMPTY) || bus.out_ready;
   assign accept   = bus.in_valid && in_ready;

`ifdef Y_OPFETCH_BYPASS_EN
   logic fwd_a;
   logic fwd_b;

   // Forward a write-back landing on the same edge; r0 is never forwarded.
   assign fwd_a     = bus.wb_we && (bus.wb_addr == bus.rs_addr) && (bus.rs_addr != '0);
   assign fwd_b     = bus.wb_we && (bus.wb_addr == bus.rt_addr) && (bus.rt_addr != '0);
   assign a_src     = fwd_a ? bus.wb_data : rf_a;
   assign b_reg_src = fwd_b ? bus.wb_data : rf_b;
`else
   // No forwarding: same-edge readers see the value before the write.
   assign a_src     = rf_a;
   assign b_reg_src = rf_b;
`endif

   // Immediate wins over the register (and any forwarded value) for b.
   assign b_src = bus.use_imm ? bus.imm : b_reg_src;

   // Next-state and operand-load logic for the EMPTY/FULL output register.
   always_comb begin
      // NOTE: every _d takes its hold value first, so no branch below can
      // leave a signal unassigned and infer a latch.
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;

      // Operands load only on accept; stalls and drains keep the last set,
      // which is why held operands never see later write-backs.
      if (accept) begin
         a_d  = a_src;
         b_d  = b_src;
         op_d = bus.op_in;
      end

      case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               state_d = ST_FULL;
            end
         end
         ST_FULL: begin
            // Accept with out_ready or a stall both stay FULL.
            if (!accept && bus.out_ready) begin
               state_d = ST_EMPTY;
            end
         end
         default: begin
            state_d = ST_EMPTY;
         end
      endcase
   end

   // State and operand registers; reset discards any pending output.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_EMPTY;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= ALU_AND;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = (state_q == ST_FULL);
   assign bus.a         = a_q;
   assign bus.b         = b_q;
   assign bus.op        = op_q;

endmodule : y_operand_fetch

// File: tb/tb_y_operand_fetch.sv
// Self-checking bench for y_operand_fetch. Table-driven vectors plus
// hand-written backpressure and mid-operation reset sequences; expected
// operand sets are queued at accept time and compared when consumed.
module tb_y_operand_fetch;
   import y_pkg::*;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   y_operand_fetch_if bus ();

   y_operand_fetch dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  op;
   } exp_t;

   typedef struct {
      logic        wb_we;
      logic [4:0]  wb_addr;
      logic [31:0] wb_data;
      logic        in_valid;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic        use_imm;
      logic [31:0] imm;
      logic [2:0]  op_in;
      logic        out_ready;
      logic [31:0] exp_a;
      logic [31:0] exp_b;
   } vec_t;

`ifdef Y_OPFETCH_BYPASS_EN
   localparam logic [31:0] HZ_A7 = 32'hAAAA5555;
   localparam logic [31:0] HZ_B9 = 32'h13579BDF;
`else
   localparam logic [31:0] HZ_A7 = 32'h0000_0000;
   localparam logic [31:0] HZ_B9 = 32'h0000_0000;
`endif

   exp_t sb[$];
   logic m_valid;
   int   checks = 0;
   int   errors = 0;
   vec_t tbl[14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic wb_we, input logic [4:0] wb_addr,
                               input logic [31:0] wb_data, input logic in_valid,
                               input logic [4:0] rs, input logic [4:0] rt,
                               input logic use_imm, input logic [31:0] imm,
                               input logic [2:0] op_in, input logic out_ready,
                               input logic [31:0] exp_a, input logic [31:0] exp_b);
      vec_t v;
      v.wb_we = wb_we;  v.wb_addr = wb_addr; v.wb_data = wb_data;
      v.in_valid = in_valid; v.rs = rs; v.rt = rt;
      v.use_imm = use_imm; v.imm = imm; v.op_in = op_in;
      v.out_ready = out_ready; v.exp_a = exp_a; v.exp_b = exp_b;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      bus.wb_we     = v.wb_we;
      bus.wb_addr   = v.wb_addr;
      bus.wb_data   = v.wb_data;
      bus.in_valid  = v.in_valid;
      bus.rs_addr   = v.rs;
      bus.rt_addr   = v.rt;
      bus.use_imm   = v.use_imm;
      bus.imm       = v.imm;
      bus.op_in     = v.op_in;
      bus.out_ready = v.out_ready;
   endtask

   task automatic idle(input logic ordy);
      drive(mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b0, 32'h0, 3'b000, ordy, 32'h0, 32'h0));
   endtask

   // One clock: compare handshake and outputs mid-cycle against the model,
   // then advance the model and the DUT across the rising edge.
   task automatic cycle(input logic [31:0] ea, input logic [31:0] eb, input logic [2:0] eop);
      exp_t e;
      logic acc;
      @(negedge clk);
      check("in_ready", 32'(bus.in_ready), 32'(!m_valid || bus.out_ready));
      check("out_valid", 32'(bus.out_valid), 32'(m_valid));
      if (m_valid) begin
         check("sb_depth", 32'(sb.size()), 32'd1);
         if (sb.size() > 0) begin
            e = sb[0];
            check(bus.out_ready ? "a_consumed" : "a_held", bus.a, e.a);
            check(bus.out_ready ? "b_consumed" : "b_held", bus.b, e.b);
            check(bus.out_ready ? "op_consumed" : "op_held", 32'(bus.op), 32'(e.op));
            if (bus.out_ready) void'(sb.pop_front());
         end
      end
      acc = bus.in_valid && (!m_valid || bus.out_ready);
      if (rst) begin
         sb.delete();
         m_valid = 1'b0;
      end else begin
         if (acc) begin
            e.a = ea; e.b = eb; e.op = eop;
            sb.push_back(e);
         end
         if (acc) m_valid = 1'b1;
         else if (m_valid && bus.out_ready) m_valid = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [2:0] sw_op;

      // Reset and idle.
      m_valid = 1'b0;
      rst = 1'b1;
      idle(1'b1);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_a", bus.a, 32'h0);
      check("rst_b", bus.b, 32'h0);
      check("rst_op", 32'(bus.op), 32'(ALU_AND));
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);

      // Every register r1..r31 reads zero after reset, back to back.
      for (int i = 1; i < 32; i++) begin
         sw_op = 3'(i);
         drive(mk(1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 5'(32 - i), 1'b0, 32'h0, sw_op, 1'b1, 32'h0, 32'h0));
         cycle(32'h0, 32'h0, sw_op);
      end
      idle(1'b1);
      cycle(32'h0, 32'h0, 3'b000);

      // Table: write/read, immediate, r0, same-edge hazards, undefined op.
      tbl[0]  = mk(1, 5'd5, 32'h12345678, 0, 5'd0, 5'd0, 0, 32'h0,        ALU_AND, 1, 32'h0, 32'h0);
      tbl[1]  = mk(1, 5'd6, 32'h0000000F, 0, 5'd0, 5'd0, 0, 32'h0,        ALU_AND, 1, 32'h0, 32'h0);
      tbl[2]  = mk(0, 5'd0, 32'h0,        1, 5'd5, 5'd6, 0, 32'h0,        ALU_ADD, 1, 32'h12345678, 32'h0000000F);
      tbl[3]  = mk(1, 5'd0, 32'hFFFFFFFF, 0, 5'd0, 5'd0, 0, 32'h0,        ALU_AND, 1, 32'h0, 32'h0);
      tbl[4]  = mk(0, 5'd0, 32'h0,        1, 5'd0, 5'd0, 1, 32'hDEADBEEF, ALU_SUB, 1, 32'h0, 32'hDEADBEEF);
      tbl[5]  = mk(0, 5'd0, 32'h0,        1, 5'd1, 5'd31, 0, 32'h0,       ALU_SLT, 1, 32'h0, 32'h0);
      tbl[6]  = mk(1, 5'd0, 32'h00000055, 1, 5'd0, 5'd0, 0, 32'h0,        ALU_AND, 1, 32'h0, 32'h0);
      tbl[7]  = mk(1, 5'd7, 32'hAAAA5555, 1, 5'd7, 5'd5, 0, 32'h0,        ALU_OR,  1, HZ_A7, 32'h12345678);
      tbl[8]  = mk(0, 5'd0, 32'h0,        1, 5'd7, 5'd7, 0, 32'h0,        3'b011,  1, 32'hAAAA5555, 32'hAAAA5555);
      tbl[9]  = mk(1, 5'd9, 32'h13579BDF, 1, 5'd6, 5'd9, 0, 32'h0,        ALU_ADD, 1, 32'h0000000F, HZ_B9);
      tbl[10] = mk(0, 5'd0, 32'h0,        1, 5'd9, 5'd0, 0, 32'h0,        3'b100,  1, 32'h13579BDF, 32'h0);
      tbl[11] = mk(1, 5'd6, 32'hCAFEF00D, 1, 5'd9, 5'd6, 1, 32'h00000001, ALU_ADD, 1, 32'h13579BDF, 32'h00000001);
      tbl[12] = mk(0, 5'd0, 32'h0,        1, 5'd6, 5'd0, 1, 32'h0000FFFF, ALU_OR,  1, 32'hCAFEF00D, 32'h0000FFFF);
      tbl[13] = mk(0, 5'd0, 32'h0,        0, 5'd0, 5'd0, 0, 32'h0,        ALU_AND, 1, 32'h0, 32'h0);
      for (int i = 0; i < 14; i++) begin
         drive(tbl[i]);
         cycle(tbl[i].exp_a, tbl[i].exp_b, tbl[i].op_in);
      end

      // Backpressure: set 1 held for 3 cycles while r5 is rewritten.
      drive(mk(0, 5'd0, 32'h0, 1, 5'd5, 5'd6, 0, 32'h0, ALU_ADD, 0, 32'h0, 32'h0));
      cycle(32'h12345678, 32'hCAFEF00D, ALU_ADD);
      drive(mk(1, 5'd5, 32'h0BADF00D, 1, 5'd6, 5'd5, 0, 32'h0, ALU_OR, 0, 32'h0, 32'h0));
      cycle(32'hCAFEF00D, 32'h0BADF00D, ALU_OR);
      drive(mk(0, 5'd0, 32'h0, 1, 5'd6, 5'd5, 0, 32'h0, ALU_OR, 0, 32'h0, 32'h0));
      cycle(32'hCAFEF00D, 32'h0BADF00D, ALU_OR);
      cycle(32'hCAFEF00D, 32'h0BADF00D, ALU_OR);
      // Release: set 1 consumed and set 2 accepted on the same edge.
      bus.out_ready = 1'b1;
      cycle(32'hCAFEF00D, 32'h0BADF00D, ALU_OR);
      idle(1'b1);
      cycle(32'h0, 32'h0, 3'b000);
      cycle(32'h0, 32'h0, 3'b000);

      // Mid-operation reset with a stalled set and a colliding write-back.
      drive(mk(0, 5'd0, 32'h0, 1, 5'd5, 5'd6, 0, 32'h0, ALU_SLT, 0, 32'h0, 32'h0));
      cycle(32'h0BADF00D, 32'hCAFEF00D, ALU_SLT);
      drive(mk(1, 5'd8, 32'h77777777, 0, 5'd0, 5'd0, 0, 32'h0, ALU_AND, 0, 32'h0, 32'h0));
      rst = 1'b1;
      cycle(32'h0, 32'h0, 3'b000);
      rst = 1'b0;
      check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      check("midrst_a", bus.a, 32'h0);
      check("midrst_b", bus.b, 32'h0);
      check("midrst_op", 32'(bus.op), 32'd0);
      drive(mk(0, 5'd0, 32'h0, 1, 5'd5, 5'd8, 0, 32'h0, ALU_OR, 1, 32'h0, 32'h0));
      cycle(32'h0, 32'h0, ALU_OR);
      idle(1'b1);
      cycle(32'h0, 32'h0, 3'b000);
      cycle(32'h0, 32'h0, 3'b000);

      check("sb_empty_at_end", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_y_operand_fetch
